instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch sequencer for the 54-instruction MIPS multi-cycle CPU, sitting directly downstream of the PC register. It captures the current PC, handshakes one word out of instruction memory, and latches it into the instruction register (IR). It then returns PC+4 and a one-cycle write strobe to the PC register's load-enable input. It also flags misaligned, out-of-text-segment and (optionally) timed-out fetches.

## Interface
Parameters:
- TEXT_BASE, 32'h0040_0000, byte address of the first instruction; equals the PC reset value
- IMEM_AW, 11, width of the word index driven to instruction memory
- TIMEOUT_CYCLES, 255, maximum cycles to wait for imem_ack (used only with the timeout feature)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- pc  in  32  current PC from the PC register
- fetch_start  in  1  control unit requests a fetch
- flush  in  1  abandon the in-flight fetch
- imem_req  out  1  memory request
- imem_addr  out  IMEM_AW  word index = (pc_q − TEXT_BASE)[IMEM_AW+1:2]
- imem_ack  in  1  memory data valid this cycle
- imem_rdata  in  32  instruction word
- ir  out  32  instruction register
- ir_valid  out  1  IR holds an unconsumed instruction
- ir_ready  in  1  consumer takes IR
- pc_next  out  32  pc_q + 4, to the PC register data input
- pc_we  out  1  one-cycle PC load strobe
- busy  out  1  state ≠ IDLE
- fault  out  1  sticky fault flag
- fault_cause  out  2  01 misaligned, 10 out of range, 11 timeout
- fault_clr  in  1  clears fault and fault_cause

## Operation
- States: IDLE, REQ, DONE, DRAIN, FAULT.
- IDLE, fetch_start=1:
  - pc_q ← pc.
  - pc[1:0]≠0 → FAULT, cause 01.
  - pc < TEXT_BASE, or (pc−TEXT_BASE)>>2 ≥ 2^IMEM_AW → FAULT, cause 10.
  - Otherwise → REQ.
- REQ:
  - imem_req=1; imem_addr is derived from the registered pc_q only, so PC changes during a fetch have no effect.
  - imem_ack=1 → ir ← imem_rdata, ir_valid ← 1, pc_we pulses, → DONE.
  - flush=1 without imem_ack → DRAIN.
  - flush and imem_ack in the same cycle → flush wins: IR is not loaded, no pc_we, → IDLE.
- DRAIN: imem_req=0; waits for the stale imem_ack, discards its data, → IDLE. flush in DRAIN has no effect.
- DONE:
  - ir_valid=1 and ir is held stable.
  - ir_ready=1 → ir_valid ← 0 → IDLE.
  - ir_ready and fetch_start in the same cycle → back-to-back fetch: range checks run on the new pc, → REQ or FAULT.
  - flush in DONE clears ir_valid → IDLE.
- FAULT: no requests are issued. fault_clr → IDLE, and fault/fault_cause ← 0. fetch_start is ignored in FAULT.
- fetch_start outside IDLE/DONE is ignored.
- pc_next is always pc_q + 4, wrapping modulo 2^32.

## Timing
- Reset values: state IDLE, ir=0, ir_valid=0, pc_we=0, imem_req=0, imem_addr=0, pc_next=TEXT_BASE+4, busy=0, fault=0, fault_cause=0.
- Asserting rst mid-fetch drops imem_req immediately (asynchronous). A late ack after reset is ignored because the block is in IDLE.
- fetch_start sampled at edge N → imem_req high from N+1.
- imem_ack at edge M → ir_valid and pc_we high during M+1.
- Zero-wait memory (ack in the first REQ cycle) gives 2 cycles from fetch_start to ir_valid.
- pc_we is high for exactly one cycle per successful fetch and never during DRAIN or FAULT.
- Fault is registered: fault goes high the cycle after the offending fetch_start.

## Configuration
- IFETCH_TIMEOUT_EN defined:
  - An 8..16-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - Reaching TIMEOUT_CYCLES → FAULT, cause 11, imem_req dropped.
  - A late ack after a timeout is ignored (the block is in FAULT).
- IFETCH_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; cause 11 never occurs.

## Structure
- Package ifetch_pkg holds the state enum, the fault-cause constants (FC_NONE, FC_MISALIGN, FC_RANGE, FC_TIMEOUT) and the default TEXT_BASE.
- One natural sub-module, ifetch_timeout_ctr (load/increment/expire), instantiated only under IFETCH_TIMEOUT_EN.

## Test plan
- pc=0x0040_0000, fetch_start, ack in the same cycle with rdata=0x2008_0005 → imem_addr=0; ir=0x2008_0005 and pc_we=1 with pc_next=0x0040_0004 two cycles after fetch_start.
- pc=0x0040_0010, ack after 3 wait cycles → imem_req held 4 cycles with imem_addr=4; exactly one pc_we pulse.
- pc=0x0040_0002 → fault=1, cause=01, imem_req never asserts; fault_clr → IDLE, fault=0.
- pc=0x003F_FFFC → cause=10; pc=TEXT_BASE + 4·2^IMEM_AW → cause=10.
- flush in the 2nd REQ cycle, ack 2 cycles later → DRAIN; ir unchanged, no pc_we, then IDLE.
- IFETCH_TIMEOUT_EN with TIMEOUT_CYCLES=4, no ack → fault with cause 11 after 4 REQ cycles. Separately: rst asserted mid-REQ → imem_req=0 immediately and all outputs at their reset values.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// fault-cause codes, default text-segment base and the PC legality check.
package ifetch_pkg;

  localparam logic [31:0] DEFAULT_TEXT_BASE = 32'h0040_0000;

  typedef logic [2:0] ifetch_state_t;
  localparam ifetch_state_t S_IDLE  = 3'd0;
  localparam ifetch_state_t S_REQ   = 3'd1;
  localparam ifetch_state_t S_DONE  = 3'd2;
  localparam ifetch_state_t S_DRAIN = 3'd3;
  localparam ifetch_state_t S_FAULT = 3'd4;

  typedef logic [1:0] fault_cause_t;
  localparam fault_cause_t FC_NONE     = 2'b00;
  localparam fault_cause_t FC_MISALIGN = 2'b01;
  localparam fault_cause_t FC_RANGE    = 2'b10;
  localparam fault_cause_t FC_TIMEOUT  = 2'b11;

  // Misalignment takes precedence over range; the range test covers both
  // PCs below the base and word offsets beyond the imem index width.
  function automatic fault_cause_t pc_check(input logic [31:0] pc,
                                            input logic [31:0] base,
                                            input int unsigned aw);
    logic [31:0] off;
    off = pc - base;
    if (pc[1:0] != 2'b00) return FC_MISALIGN;
    if ((pc < base) || ((off >> (aw + 2)) != 32'd0)) return FC_RANGE;
    return FC_NONE;
  endfunction

endpackage

// File: rtl/ifetch_timeout_ctr.sv
// Fetch wait-cycle counter: cleared on load, counts wait cycles, flags
// expiry on the LIMIT-th counted cycle.
module ifetch_timeout_ctr #(
  parameter int W     = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = inc && (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: captures PC, fetches one word from imem into IR,
// strobes PC+4 back to the PC register. Optional fetch timeout: IFETCH_TIMEOUT_EN.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] TEXT_BASE      = DEFAULT_TEXT_BASE,
  parameter int          IMEM_AW        = 11,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        pc,
  input  logic               fetch_start,
  input  logic               flush,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        ir,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [31:0]        pc_next,
  output logic               pc_we,
  output logic               busy,
  output logic               fault,
  output logic [1:0]         fault_cause,
  input  logic               fault_clr,
  output logic [2:0]         state_dbg
);

  // Handshakes: imem_req stays high until a cycle with imem_ack (data
  // accepted that cycle); ir_valid stays high with ir stable until a
  // cycle with ir_ready (instruction consumed that cycle).

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("instr_fetch: TIMEOUT_CYCLES must be in 1..65535");
  end

  ifetch_state_t state;
  logic [31:0]   pc_q;
  logic          launch;
  fault_cause_t  launch_cause;
  logic          timeout_hit;

  assign launch = fetch_start &&
                  ((state == S_IDLE) || (state == S_DONE && ir_ready && !flush));
  assign launch_cause = pc_check(pc, TEXT_BASE, IMEM_AW);

`ifdef IFETCH_TIMEOUT_EN
  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);

  ifetch_timeout_ctr #(
    .W     (TW),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .load    (launch && (launch_cause == FC_NONE)),
    .inc     ((state == S_REQ) && !imem_ack),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc_q        <= TEXT_BASE;
      ir          <= '0;
      ir_valid    <= 1'b0;
      pc_we       <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= FC_NONE;
    end else begin
      pc_we <= 1'b0;
      case (state)
        S_IDLE: ;
        S_REQ: begin
          // A flush racing the ack wins; a flush without ack must still
          // swallow the stale ack that is on its way.
          if (flush) begin
            state <= imem_ack ? S_IDLE : S_DRAIN;
          end else if (imem_ack) begin
            ir       <= imem_rdata;
            ir_valid <= 1'b1;
            pc_we    <= 1'b1;
            state    <= S_DONE;
          end else if (timeout_hit) begin
            fault       <= 1'b1;
            fault_cause <= FC_TIMEOUT;
            state       <= S_FAULT;
          end
        end
        S_DONE: begin
          if (flush || ir_ready) begin
            ir_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (imem_ack) state <= S_IDLE;
        end
        S_FAULT: begin
          if (fault_clr) begin
            fault       <= 1'b0;
            fault_cause <= FC_NONE;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Applies to both the IDLE start and the back-to-back start from DONE.
      if (launch) begin
        pc_q <= pc;
        if (launch_cause != FC_NONE) begin
          fault       <= 1'b1;
          fault_cause <= launch_cause;
          state       <= S_FAULT;
        end else begin
          state <= S_REQ;
        end
      end
    end
  end

  assign imem_req  = (state == S_REQ);
  assign imem_addr = IMEM_AW'((pc_q - TEXT_BASE) >> 2);
  assign pc_next   = pc_q + 32'd4;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: reset values, table-driven fetches,
// hand-written flush/drain/back-to-back/reset/timeout sequences, random fetches.
module tb_instr_fetch;

  localparam logic [31:0] BASE = 32'h0040_0000;
  localparam int          AW   = 11;
  localparam int          TO   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   pc;
  logic          fetch_start, flush, imem_ack, ir_ready, fault_clr;
  logic [31:0]   imem_rdata;
  logic          imem_req, ir_valid, pc_we, busy, fault;
  logic [AW-1:0] imem_addr;
  logic [31:0]   ir, pc_next;
  logic [1:0]    fault_cause;
  logic [2:0]    state_dbg;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [31:0]   exp_q[$];
  logic [31:0]   last_ir = 32'd0;

  typedef struct {
    logic [31:0] pc;
    int          waits;
    logic [31:0] rdata;
    int          cause;
    logic [31:0] addr;
  } vec_t;
  vec_t vecs[9];

  always #5 clk = ~clk;

  instr_fetch #(
    .TEXT_BASE      (BASE),
    .IMEM_AW        (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .fetch_start (fetch_start),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .pc_next     (pc_next),
    .pc_we       (pc_we),
    .busy        (busy),
    .fault       (fault),
    .fault_cause (fault_cause),
    .fault_clr   (fault_clr),
    .state_dbg   (state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_start = 1'b0;
    flush       = 1'b0;
    imem_ack    = 1'b0;
    ir_ready    = 1'b0;
    fault_clr   = 1'b0;
    imem_rdata  = $urandom;
  endtask

  // Reference rules: word aligned, inside [BASE, BASE + 4*2^AW).
  function automatic int model_cause(input logic [31:0] p);
    if (p % 4 != 0) return 1;
    if (p < BASE) return 2;
    if ((p - BASE) / 4 >= 32'(1 << AW)) return 2;
    return 0;
  endfunction

  task automatic run_fetch(input string tag, input logic [31:0] p, input int waits,
                           input logic [31:0] rd, input int exp_cause,
                           input logic [31:0] exp_addr);
    int req_cycles = 0;
    int we_pulses  = 0;
    int cycles     = 0;
    logic [31:0] exp_ir;
    pc = p;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    if (exp_cause != 0) begin
      check({tag, ".fault"}, 32'(fault), 32'd1);
      check({tag, ".cause"}, 32'(fault_cause), 32'(exp_cause));
      check({tag, ".no_req"}, 32'(imem_req), 32'd0);
      fetch_start = 1'b1;
      step();
      fetch_start = 1'b0;
      check({tag, ".start_ignored"}, {30'd0, imem_req, fault}, 32'd1);
      fault_clr = 1'b1;
      step();
      fault_clr = 1'b0;
      check({tag, ".cleared"}, {29'd0, busy, fault_cause}, 32'd0);
      check({tag, ".fault_low"}, 32'(fault), 32'd0);
    end else begin
      exp_q.push_back(rd);
      check({tag, ".addr"}, 32'(imem_addr), exp_addr);
      while (ir_valid !== 1'b1 && cycles < waits + 10) begin
        if (imem_req === 1'b1) req_cycles++;
        if (req_cycles == waits + 1) begin
          imem_ack   = 1'b1;
          imem_rdata = rd;
        end
        pc = $urandom;
        step();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (pc_we === 1'b1) we_pulses++;
        cycles++;
      end
      check({tag, ".ir_valid"}, 32'(ir_valid), 32'd1);
      check({tag, ".latency"}, 32'(cycles), 32'(waits + 1));
      check({tag, ".req_cycles"}, 32'(req_cycles), 32'(waits + 1));
      exp_ir = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      check({tag, ".ir"}, ir, exp_ir);
      check({tag, ".pc_next"}, pc_next, p + 32'd4);
      step();
      if (pc_we === 1'b1) we_pulses++;
      check({tag, ".we_pulses"}, 32'(we_pulses), 32'd1);
      check({tag, ".ir_hold"}, ir, rd);
      ir_ready = 1'b1;
      step();
      ir_ready = 1'b0;
      check({tag, ".consumed"}, {30'd0, ir_valid, busy}, 32'd0);
      last_ir = rd;
    end
  endtask

  initial begin
    #400000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    vecs[0] = '{32'h0040_0000, 0, 32'h2008_0005, 0, 32'd0};
    vecs[1] = '{32'h0040_0010, 3, 32'h8C09_0004, 0, 32'd4};
    vecs[2] = '{32'h0040_0002, 0, 32'h0,         1, 32'd0};
    vecs[3] = '{32'h003F_FFFC, 0, 32'h0,         2, 32'd0};
    vecs[4] = '{32'h0040_2000, 0, 32'h0,         2, 32'd0};
    vecs[5] = '{32'h0040_1FFC, 1, 32'hAC0A_0008, 0, 32'd2047};
    vecs[6] = '{32'h0040_0003, 2, 32'h0,         1, 32'd0};
    vecs[7] = '{32'h0000_0000, 0, 32'h0,         2, 32'd0};
    vecs[8] = '{32'hFFFF_FFFC, 0, 32'h0,         2, 32'd0};

    rst = 1'b1;
    pc  = BASE;
    idle_inputs();
    step();
    step();
    check("rst.ir", ir, 32'd0);
    check("rst.flags", {27'd0, ir_valid, pc_we, imem_req, busy, fault}, 32'd0);
    check("rst.cause", 32'(fault_cause), 32'd0);
    check("rst.addr", 32'(imem_addr), 32'd0);
    check("rst.pc_next", pc_next, BASE + 32'd4);
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      run_fetch($sformatf("vec%0d", i), vecs[i].pc, vecs[i].waits, vecs[i].rdata,
                vecs[i].cause, vecs[i].addr);
    end

    // Flush in the second REQ cycle, stale ack two cycles later.
    pc = BASE + 32'h20;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("drain.enter", {29'd0, imem_req, busy, pc_we}, 32'd2);
    step();
    check("drain.wait", {29'd0, imem_req, busy, pc_we}, 32'd2);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    flush      = 1'b1;
    step();
    idle_inputs();
    check("drain.exit", {29'd0, busy, ir_valid, pc_we}, 32'd0);
    check("drain.ir", ir, last_ir);

    // Flush and ack in the same REQ cycle: flush wins.
    pc = BASE + 32'h24;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    flush      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    step();
    idle_inputs();
    check("flush_ack.state", {29'd0, busy, ir_valid, pc_we}, 32'd0);
    check("flush_ack.ir", ir, last_ir);
    step();
    check("flush_ack.no_we", 32'(pc_we), 32'd0);

    // Back-to-back fetch out of DONE, then flush while holding IR.
    pc = BASE + 32'h40;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0020;
    step();
    imem_ack = 1'b0;
    check("b2b.first_ir", ir, 32'h0000_0020);
    pc = BASE + 32'h44;
    ir_ready    = 1'b1;
    fetch_start = 1'b1;
    step();
    ir_ready    = 1'b0;
    fetch_start = 1'b0;
    check("b2b.req", {30'd0, imem_req, ir_valid}, 32'd2);
    check("b2b.addr", 32'(imem_addr), 32'h11);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0044;
    step();
    imem_ack = 1'b0;
    check("b2b.second_ir", ir, 32'h0000_0044);
    check("b2b.pc_next", pc_next, BASE + 32'h48);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("done_flush", {30'd0, ir_valid, busy}, 32'd0);
    last_ir = 32'h0000_0044;

`ifdef IFETCH_TIMEOUT_EN
    begin
      int n_req = 0;
      pc = BASE + 32'h80;
      fetch_start = 1'b1;
      step();
      fetch_start = 1'b0;
      for (int k = 0; k < 12; k++) begin
        if (fault === 1'b1) break;
        if (imem_req === 1'b1) n_req++;
        step();
      end
      check("timeout.req_cycles", 32'(n_req), 32'(TO));
      check("timeout.cause", {29'd0, fault, fault_cause}, 32'h7);
      check("timeout.no_req", 32'(imem_req), 32'd0);
      imem_ack = 1'b1;
      step();
      imem_ack = 1'b0;
      check("timeout.late_ack", {29'd0, fault, ir_valid, pc_we}, 32'h4);
      fault_clr = 1'b1;
      step();
      fault_clr = 1'b0;
      check("timeout.clear", {29'd0, busy, fault_cause}, 32'd0);
    end
`endif

    // Asynchronous reset in the middle of a REQ.
    pc = BASE + 32'h100;
    fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    check("arst.pre_req", 32'(imem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("arst.req_drop", 32'(imem_req), 32'd0);
    check("arst.outputs", {27'd0, ir_valid, pc_we, busy, fault, 1'b0}, 32'd0);
    check("arst.ir", ir, 32'd0);
    check("arst.pc_next", pc_next, BASE + 32'd4);
    check("arst.addr", 32'(imem_addr), 32'd0);
    #1;
    rst      = 1'b0;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    check("arst.late_ack", {29'd0, busy, ir_valid, pc_we}, 32'd0);
    last_ir = 32'd0;

    // Random fetches against the reference rules.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] rp;
      int          sel;
      sel = $urandom_range(0, 3);
      if (sel <= 1)      rp = BASE + 32'(4 * $urandom_range(0, (1 << AW) - 1));
      else if (sel == 2) rp = {$urandom} & 32'hFFFF_FFFC;
      else               rp = $urandom;
      run_fetch($sformatf("rnd%0d", i), rp, $urandom_range(0, 3), $urandom,
                model_cause(rp), (rp - BASE) / 4);
    end

    check("scoreboard.empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
